// File: rtl/gb_host_pkg.sv
// Shared types and constants for the GB host bus master.
package gb_host_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR      = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_RSP     = 2'd3
    } state_t;

    // Legal peripheral read latency range and the counter width that covers it
    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 15;
    localparam int unsigned LAT_W      = 4;

endpackage

// File: rtl/gb_host_master.sv
// GB host bus master: turns single commands into write bursts (one gb_we
// pulse per beat) or read bursts (one response per beat, back-pressured).
// Optional feature macro: GB_HOST_BURST_EN (defined: req_len honoured;
// undefined: every command is a single beat).
module gb_host_master
    import gb_host_pkg::*;
#(
    parameter int unsigned AW     = 24,
    parameter int unsigned DW     = 32,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned LW     = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    input  logic [LW-1:0] req_len,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic [AW-1:0] gb_addr,
    output logic [DW-1:0] gb_dout,
    output logic          gb_we,
    input  logic [DW-1:0] gb_din
);

    // Out-of-range latencies are clamped into the legal window
    localparam int unsigned LAT_LIM = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                                      (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_req_ready;
    logic            r_rsp_valid;
    logic [DW-1:0]   r_rsp_rdata;
    logic [AW-1:0]   r_gb_addr;
    logic [DW-1:0]   r_gb_dout;
    logic            r_gb_we;
    logic [LW-1:0]   r_beat_cnt;
    logic [LAT_W-1:0] r_lat_cnt;

    logic            w_req_ready_nxt;
    logic            w_rsp_valid_nxt;
    logic [DW-1:0]   w_rsp_rdata_nxt;
    logic [AW-1:0]   w_gb_addr_nxt;
    logic [DW-1:0]   w_gb_dout_nxt;
    logic            w_gb_we_nxt;
    logic [LW-1:0]   w_beat_cnt_nxt;
    logic [LAT_W-1:0] w_lat_cnt_nxt;

    logic            w_accept;
    logic            w_beat_last;
    logic            w_lat_done;
    logic [LW-1:0]   w_len_eff;

    assign w_accept    = req_valid && r_req_ready;
    assign w_beat_last = (r_beat_cnt == '0);
    assign w_lat_done  = (r_lat_cnt == LAT_W'(LAT_LIM));

    // Remaining-beats load value; single-beat builds discard the length field
`ifdef GB_HOST_BURST_EN
    assign w_len_eff = req_len;
`else
    assign w_len_eff = req_len & LW'(0);
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_accept) w_state_nxt = req_we ? ST_WR : ST_RD_WAIT;
            ST_WR:      if (w_beat_last) w_state_nxt = ST_IDLE;
            ST_RD_WAIT: if (w_lat_done) w_state_nxt = ST_RSP;
            ST_RSP:     if (rsp_ready) w_state_nxt = w_beat_last ? ST_IDLE : ST_RD_WAIT;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values for the registered outputs and counters
    always_comb begin
        w_req_ready_nxt = (w_state_nxt == ST_IDLE);
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_gb_addr_nxt   = r_gb_addr;
        w_gb_dout_nxt   = r_gb_dout;
        w_gb_we_nxt     = 1'b0;
        w_beat_cnt_nxt  = r_beat_cnt;
        w_lat_cnt_nxt   = r_lat_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_gb_addr_nxt  = req_addr;
                    w_beat_cnt_nxt = w_len_eff;
                    w_lat_cnt_nxt  = '0;
                    w_gb_we_nxt    = req_we;
                    if (req_we) w_gb_dout_nxt = req_wdata;
                end
            end
            ST_WR: begin
                if (!w_beat_last) begin
                    w_gb_addr_nxt  = r_gb_addr + AW'(1);
                    w_beat_cnt_nxt = r_beat_cnt - LW'(1);
                    w_gb_we_nxt    = 1'b1;
                end
            end
            ST_RD_WAIT: begin
                if (w_lat_done) begin
                    w_rsp_rdata_nxt = gb_din;
                    w_rsp_valid_nxt = 1'b1;
                end else begin
                    w_lat_cnt_nxt = r_lat_cnt + LAT_W'(1);
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    if (!w_beat_last) begin
                        w_gb_addr_nxt  = r_gb_addr + AW'(1);
                        w_beat_cnt_nxt = r_beat_cnt - LW'(1);
                        w_lat_cnt_nxt  = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    // Output and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_gb_addr   <= '0;
            r_gb_dout   <= '0;
            r_gb_we     <= 1'b0;
            r_beat_cnt  <= '0;
            r_lat_cnt   <= '0;
        end else begin
            r_req_ready <= w_req_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_gb_addr   <= w_gb_addr_nxt;
            r_gb_dout   <= w_gb_dout_nxt;
            r_gb_we     <= w_gb_we_nxt;
            r_beat_cnt  <= w_beat_cnt_nxt;
            r_lat_cnt   <= w_lat_cnt_nxt;
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign gb_addr   = r_gb_addr;
    assign gb_dout   = r_gb_dout;
    assign gb_we     = r_gb_we;

endmodule

// File: doc/gb_host_master.md
GB_HOST_MASTER -- requirements
Module: gb_host_master

Interface
- REQ-001 SHALL have parameter AW, default 24, bus address width.
- REQ-002 SHALL have parameter DW, default 32, bus data width.
- REQ-003 SHALL have parameter RD_LAT, default 1, peripheral read latency in cycles; legal range 1..15.
- REQ-004 SHALL have parameter LW, default 8, burst length field width.
- REQ-005 SHALL have the following ports, one per line (name, direction, width, meaning):
  - clk  in  1  sole clock.
  - rst  in  1  reset; asynchronous, active-high.
  - req_valid  in  1  command offered.
  - req_ready  out  1  command accepted when high with req_valid.
  - req_we  in  1  1 = write burst, 0 = read burst.
  - req_addr  in  AW  start address.
  - req_wdata  in  DW  write data, same value for every beat.
  - req_len  in  LW  beats minus one.
  - rsp_valid  out  1  read data available.
  - rsp_ready  in  1  read data consumed when high with rsp_valid.
  - rsp_rdata  out  DW  read data.
  - gb_addr  out  AW  bus address to peripherals.
  - gb_dout  out  DW  bus write data to peripherals.
  - gb_we  out  1  bus write strobe.
  - gb_din  in  DW  bus read data from peripherals.

Function
- REQ-006 SHALL implement states IDLE, WR, RD_WAIT, RSP.
- REQ-007 SHALL assert req_ready only in IDLE.
- REQ-008 On acceptance, SHALL latch addr, wdata, we and len, and enter WR if req_we=1, else RD_WAIT.
- REQ-009 All gb_* outputs SHALL be registered; the first beat's gb_addr is valid the cycle after acceptance.
- REQ-010 WR SHALL:
  - assert gb_we for exactly one cycle per beat, with gb_addr and gb_dout valid in that cycle;
  - issue beats on consecutive cycles;
  - return to IDLE after the final beat, with gb_we low from the following cycle.
- REQ-011 Writes SHALL produce no response.
- REQ-012 RD_WAIT SHALL:
  - hold gb_addr for RD_LAT cycles;
  - sample gb_din in the RD_LAT-th cycle after the cycle gb_addr first shows the beat address;
  - then enter RSP.
- REQ-013 In RSP, rsp_valid SHALL be high and rsp_rdata SHALL stay stable until rsp_ready.
- REQ-014 When rsp_valid and rsp_ready are both high, SHALL take the next read beat (address incremented, back to RD_WAIT) if beats remain, else return to IDLE.
- REQ-015 gb_we SHALL never be high outside WR.
- REQ-016 Beat address SHALL increment by 1 per beat, modulo 2^AW; wrap from all-ones to 0 is legal and not flagged.
- REQ-017 Beat count SHALL be req_len+1; req_len=all-ones yields 2^LW beats.
- REQ-018 gb_dout SHALL hold its last value when not writing.

Reset
- REQ-019 rst SHALL asynchronously force:
  - state IDLE;
  - req_ready=0 while rst is high, then 1 from the first cycle after release;
  - rsp_valid=0, rsp_rdata=0;
  - gb_addr=0, gb_dout=0, gb_we=0;
  - beat counter and latency counter to 0.
- REQ-020 Reset mid-burst SHALL abandon the burst without any further gb_we pulse or response.

Configuration
- REQ-021 Macro GB_HOST_BURST_EN defined: req_len SHALL be honoured as above.
- REQ-022 Macro GB_HOST_BURST_EN undefined: req_len SHALL be ignored and every command is one beat; ports are unchanged.

Structure
- REQ-023 Package gb_host_pkg SHALL hold the state enum and the RD_LAT range limit constant.
- REQ-024 No sub-module; the latency counter and beat counter SHALL be local to gb_host_master.

Verification
- REQ-025 Write, len=0, addr 0x000010, data 0xDEADBEEF -> single gb_we pulse with gb_addr=0x10 and gb_dout=0xDEADBEEF on cycle 1 after acceptance; no rsp_valid.
- REQ-026 Read, len=3, addr 0x100, RD_LAT=2, peripheral model returning addr^0xA5, rsp_ready tied high -> four responses 0x1A5, 0x1A4, 0x1A7, 0x1A6; each rsp_valid 3 cycles after its gb_addr change.
- REQ-027 Read with rsp_ready held low 10 cycles -> rsp_valid and rsp_rdata stable throughout; gb_addr unchanged; next beat starts the cycle after handshake.
- REQ-028 Write burst len=2 from 0xFFFFFF (AW=24) -> gb_addr sequence 0xFFFFFF, 0x000000, 0x000001 on consecutive cycles.
- REQ-029 rst asserted during beat 2 of a 4-beat write -> gb_we low immediately; no further pulses; req_ready high the first cycle after release.
- REQ-030 GB_HOST_BURST_EN undefined, read len=5 -> exactly one response, then req_ready high.
